// File: rtl/fsic_io_serdes_tx.sv
// FSIC IO serdes lane transmitter: pCLK_RATIO-bit words out LSB first, one bit per ioclk.
// Latency: push into an empty FIFO reaches the pin one cycle after the next slot edge; lead-in is pTX_LEAD cycles.
// Backpressure: txdata_in_ready = !full. Optional FSIC_SERDES_TX_UNDERRUN_CNT_EN adds a saturating underrun counter.

module fsic_io_serdes_tx_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          ioclk,
  input  logic          axis_rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [LW-1:0] level
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  assign head_dat = mem[rd_ptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module fsic_io_serdes_tx #(
  parameter int pCLK_RATIO    = 4,
  parameter int pTxFIFO_DEPTH = 2,
  parameter int pTX_LEAD      = 4
) (
  input  logic                                 ioclk,
  input  logic                                 axis_rst_n,
  input  logic                                 txen,
  input  logic [pCLK_RATIO-1:0]                txdata_in,
  input  logic                                 txdata_in_valid,
  output logic                                 txdata_in_ready,
  output logic                                 Serial_Data_out,
  output logic                                 txen_out,
  output logic                                 tx_underrun,
`ifdef FSIC_SERDES_TX_UNDERRUN_CNT_EN
  output logic [15:0]                          tx_underrun_cnt,
`endif
  output logic [$clog2(pTxFIFO_DEPTH+1)-1:0]   tx_fifo_level
);
  localparam int LW = $clog2(pTxFIFO_DEPTH + 1);
  localparam int PW = $clog2(pCLK_RATIO);
  localparam int CW = $clog2(pTX_LEAD + 1);

  typedef enum logic [1:0] {IDLE, LEAD, RUN, DRAIN} state_t;

  state_t                state;
  logic [PW-1:0]         phase_cnt;
  logic [CW-1:0]         lead_cnt;
  logic [pCLK_RATIO-1:0] shreg;
  logic [pCLK_RATIO-1:0] head_dat;
  logic [pCLK_RATIO-1:0] load_word;
  logic                  fifo_empty, slot_edge, lead_done, load, push, pop;

  assign txdata_in_ready = (tx_fifo_level != LW'(pTxFIFO_DEPTH));
  assign fifo_empty      = (tx_fifo_level == '0);
  assign push            = txdata_in_valid && txdata_in_ready;
  assign slot_edge       = ((state == RUN) || (state == DRAIN)) && (phase_cnt == PW'(pCLK_RATIO - 1));
  assign lead_done       = (state == LEAD) && (lead_cnt == CW'(pTX_LEAD - 1));
  // A slot is only filled when the lane stays enabled; a drain ending leaves the FIFO untouched.
  assign load            = txen && (lead_done || slot_edge);
  assign pop             = load && !fifo_empty;
  assign load_word       = fifo_empty ? '0 : head_dat;

  fsic_io_serdes_tx_fifo #(.W(pCLK_RATIO), .DEPTH(pTxFIFO_DEPTH), .LW(LW)) u_fifo (
    .ioclk      (ioclk),
    .axis_rst_n (axis_rst_n),
    .push       (push),
    .push_dat   (txdata_in),
    .pop        (pop),
    .head_dat   (head_dat),
    .level      (tx_fifo_level)
  );

  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state           <= IDLE;
      phase_cnt       <= '0;
      lead_cnt        <= '0;
      shreg           <= '0;
      Serial_Data_out <= 1'b0;
      txen_out        <= 1'b0;
      tx_underrun     <= 1'b0;
    end else begin
      tx_underrun <= load && fifo_empty;
      if (load) begin
        state           <= RUN;
        phase_cnt       <= '0;
        shreg           <= load_word >> 1;
        Serial_Data_out <= load_word[0];
      end else begin
        case (state)
          IDLE: begin
            Serial_Data_out <= 1'b0;
            lead_cnt        <= '0;
            if (txen) begin
              state    <= LEAD;
              txen_out <= 1'b1;
            end
          end
          LEAD: begin
            lead_cnt <= lead_cnt + 1'b1;
            if (!txen) begin
              state    <= IDLE;
              txen_out <= 1'b0;
            end
          end
          default: begin
            if (slot_edge) begin
              state           <= IDLE;
              txen_out        <= 1'b0;
              Serial_Data_out <= 1'b0;
              shreg           <= '0;
              phase_cnt       <= '0;
            end else begin
              state           <= txen ? RUN : DRAIN;
              phase_cnt       <= phase_cnt + 1'b1;
              Serial_Data_out <= shreg[0];
              shreg           <= shreg >> 1;
            end
          end
        endcase
      end
    end
  end

`ifdef FSIC_SERDES_TX_UNDERRUN_CNT_EN
  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n)                             tx_underrun_cnt <= '0;
    else if (tx_underrun && tx_underrun_cnt != 16'hFFFF) tx_underrun_cnt <= tx_underrun_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_fsic_io_serdes_tx.sv
// Directed bench for fsic_io_serdes_tx (pCLK_RATIO=4, pTxFIFO_DEPTH=2, pTX_LEAD=4).
module tb_fsic_io_serdes_tx;
  logic       ioclk = 1'b0;
  logic       axis_rst_n = 1'b0;
  logic       txen = 1'b0;
  logic [3:0] txdata_in = 4'h0;
  logic       txdata_in_valid = 1'b0;
  logic       txdata_in_ready, Serial_Data_out, txen_out, tx_underrun;
  logic [1:0] tx_fifo_level;
`ifdef FSIC_SERDES_TX_UNDERRUN_CNT_EN
  logic [15:0] tx_underrun_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [3:0] exp_w [0:15];

  fsic_io_serdes_tx #(.pCLK_RATIO(4), .pTxFIFO_DEPTH(2), .pTX_LEAD(4)) dut (
    .ioclk           (ioclk),
    .axis_rst_n      (axis_rst_n),
    .txen            (txen),
    .txdata_in       (txdata_in),
    .txdata_in_valid (txdata_in_valid),
    .txdata_in_ready (txdata_in_ready),
    .Serial_Data_out (Serial_Data_out),
    .txen_out        (txen_out),
    .tx_underrun     (tx_underrun),
`ifdef FSIC_SERDES_TX_UNDERRUN_CNT_EN
    .tx_underrun_cnt (tx_underrun_cnt),
`endif
    .tx_fifo_level   (tx_fifo_level)
  );

  always #5 ioclk = ~ioclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Presents one word and holds valid until a rising edge accepts it (ready seen high at a falling edge).
  task automatic push_word(input logic [3:0] w);
    int guard = 0;
    txdata_in = w;
    txdata_in_valid = 1'b1;
    while (!txdata_in_ready && guard < 60) begin
      @(negedge ioclk);
      guard++;
    end
    check_eq("push_ready", txdata_in_ready, 1);
    @(negedge ioclk);
    txdata_in_valid = 1'b0;
  endtask

  // Called at the falling edge where txen was just raised; checks lead-in, nwords words, nidle idle slots,
  // drops txen on the final bit and checks the lane goes quiet.
  task automatic expect_lane(input int nwords, input int nidle);
    for (int i = 0; i < 4; i++) begin
      @(negedge ioclk);
      check_eq("lead_txen_out", txen_out, 1);
      check_eq("lead_bit", Serial_Data_out, 0);
      check_eq("lead_underrun", tx_underrun, 0);
    end
    for (int k = 0; k < nwords + nidle; k++) begin
      for (int p = 0; p < 4; p++) begin
        logic [3:0] w;
        w = (k < nwords) ? exp_w[k] : 4'h0;
        @(negedge ioclk);
        check_eq("bit", Serial_Data_out, w[p]);
        check_eq("run_txen_out", txen_out, 1);
        check_eq("underrun", tx_underrun, (k >= nwords && p == 0) ? 1 : 0);
        if (k == nwords + nidle - 1 && p == 3) txen = 1'b0;
      end
    end
    @(negedge ioclk);
    check_eq("end_txen_out", txen_out, 0);
    check_eq("end_bit", Serial_Data_out, 0);
    check_eq("end_underrun", tx_underrun, 0);
  endtask

  initial begin
    // Reset state
    @(negedge ioclk);
    check_eq("rst_bit", Serial_Data_out, 0);
    check_eq("rst_txen_out", txen_out, 0);
    check_eq("rst_ready", txdata_in_ready, 1);
    check_eq("rst_level", tx_fifo_level, 0);
    check_eq("rst_underrun", tx_underrun, 0);
    axis_rst_n = 1'b1;
    @(negedge ioclk);

    // Preload A,5; a third word waits on a full FIFO and goes in once a slot pops
    push_word(4'hA);
    check_eq("pre_level1", tx_fifo_level, 1);
    push_word(4'h5);
    exp_w[0] = 4'hA; exp_w[1] = 4'h5; exp_w[2] = 4'h3;
    fork
      push_word(4'h3);
      begin
        check_eq("full_level", tx_fifo_level, 2);
        check_eq("full_ready", txdata_in_ready, 0);
        @(negedge ioclk);
        check_eq("full_hold_level", tx_fifo_level, 2);
        check_eq("full_hold_ready", txdata_in_ready, 0);
        check_eq("idle_txen_out", txen_out, 0);
        txen = 1'b1;
        expect_lane(3, 2);
      end
    join
    check_eq("after_level", tx_fifo_level, 0);
`ifdef FSIC_SERDES_TX_UNDERRUN_CNT_EN
    check_eq("underrun_cnt", tx_underrun_cnt, 2);
`endif

    // Continuous stream 1..F with valid held
    for (int i = 0; i < 15; i++) exp_w[i] = 4'(i + 1);
    fork
      for (int w = 1; w <= 15; w++) push_word(4'(w));
      begin
        repeat (3) @(negedge ioclk);
        check_eq("stream_full_level", tx_fifo_level, 2);
        check_eq("stream_full_ready", txdata_in_ready, 0);
        txen = 1'b1;
        expect_lane(15, 0);
      end
    join
    check_eq("stream_level", tx_fifo_level, 0);

    // Disable mid-word: C completes, 6 stays queued, then goes out after a new lead-in
    push_word(4'hC);
    push_word(4'h6);
    txen = 1'b1;
    repeat (4) @(negedge ioclk);
    @(negedge ioclk);
    check_eq("drain_b0", Serial_Data_out, 0);
    @(negedge ioclk);
    check_eq("drain_b1", Serial_Data_out, 0);
    txen = 1'b0;
    @(negedge ioclk);
    check_eq("drain_b2", Serial_Data_out, 1);
    check_eq("drain_txen_out", txen_out, 1);
    @(negedge ioclk);
    check_eq("drain_b3", Serial_Data_out, 1);
    check_eq("drain_txen_out3", txen_out, 1);
    @(negedge ioclk);
    check_eq("drain_off", txen_out, 0);
    check_eq("drain_off_bit", Serial_Data_out, 0);
    check_eq("drain_level", tx_fifo_level, 1);
    check_eq("drain_underrun", tx_underrun, 0);
    @(negedge ioclk);
    check_eq("drain_level_kept", tx_fifo_level, 1);
    exp_w[0] = 4'h6;
    txen = 1'b1;
    expect_lane(1, 0);

    // Asynchronous reset mid-word
    push_word(4'hF);
    push_word(4'hF);
    txen = 1'b1;
    repeat (6) @(negedge ioclk);
    check_eq("pre_rst_bit", Serial_Data_out, 1);
    check_eq("pre_rst_level", tx_fifo_level, 1);
    #2 axis_rst_n = 1'b0;
    #1;
    check_eq("arst_bit", Serial_Data_out, 0);
    check_eq("arst_txen_out", txen_out, 0);
    check_eq("arst_ready", txdata_in_ready, 1);
    check_eq("arst_level", tx_fifo_level, 0);
    check_eq("arst_underrun", tx_underrun, 0);
`ifdef FSIC_SERDES_TX_UNDERRUN_CNT_EN
    check_eq("arst_cnt", tx_underrun_cnt, 0);
`endif
    txen = 1'b0;
    @(negedge ioclk);
    axis_rst_n = 1'b1;
    @(negedge ioclk);
    check_eq("post_rst_txen_out", txen_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
